// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and widths for the unified fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Access presented to the memory by the arbitration winner
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and memory port bundled for the unified memory arbiter.
interface unified_mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter_arb_prio_starve.sv
// Data-priority winner select with a saturating counter that forces a fetch
// grant after STARVE_LIMIT consecutive data grants.
module arb_prio_starve
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_arb_en,
  input  logic   i_if_req,
  input  logic   i_d_req,
  output logic   o_grant_c,
  output owner_t o_winner_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_if_wins;
  logic             w_starved;

  assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_if_wins  = i_if_req && (!i_d_req || w_starved);
  assign o_grant_c  = i_arb_en && (i_if_req || i_d_req);
  assign o_winner_c = w_if_wins ? OWN_IF : OWN_D;

  // Counts data grants that bypassed a pending fetch; saturates at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (i_arb_en) begin
      if (!i_if_req || w_if_wins) begin
        r_starve_cnt <= '0;
      end else if (i_d_req && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and data ports,
// one access outstanding, fixed read latency, back-to-back grants in the response cycle.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);

  localparam int unsigned      LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  state_t           r_state, w_state_nxt;
  owner_t           r_owner, w_owner_nxt;
  logic             r_own_we, w_own_we_nxt;
  logic [LAT_W-1:0] r_lat_cnt, w_lat_cnt_nxt;
  logic             w_arb_en;
  logic             w_grant;
  logic             w_resp;
  owner_t           w_winner;
  mem_req_t         w_req;
  logic             w_unused;

  assign w_arb_en = !reset && ((r_state == ST_IDLE) || (r_lat_cnt == '0));
  assign w_resp   = !reset && (r_state == ST_WAIT) && (r_lat_cnt == '0);
  assign w_unused = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  arb_prio_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_arb_en   (w_arb_en),
    .i_if_req   (bus.if_req),
    .i_d_req    (bus.d_req),
    .o_grant_c  (w_grant),
    .o_winner_c (w_winner)
  );

  // Winner's access, all-zero when nothing is granted
  always_comb begin
    w_req = '0;
    if (w_grant) begin
      if (w_winner == OWN_D) begin
        w_req.we    = bus.d_we;
        w_req.addr  = bus.d_addr[31:2];
        w_req.wdata = bus.d_wdata;
      end else begin
        w_req.addr  = bus.if_addr[31:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_IF;
      r_own_we  <= 1'b0;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_own_we  <= w_own_we_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_own_we_nxt  = r_own_we;
    w_lat_cnt_nxt = r_lat_cnt;

    bus.if_gnt    = w_grant && (w_winner == OWN_IF);
    bus.d_gnt     = w_grant && (w_winner == OWN_D);
    bus.mem_en    = w_grant;
    bus.mem_we    = w_req.we;
    bus.mem_addr  = w_req.addr;
    bus.mem_wdata = w_req.wdata;
    bus.if_rvalid = w_resp && (r_owner == OWN_IF);
    bus.d_rvalid  = w_resp && (r_owner == OWN_D);
    bus.if_rdata  = (w_resp && (r_owner == OWN_IF)) ? bus.mem_rdata : '0;
    bus.d_rdata   = (w_resp && (r_owner == OWN_D) && !r_own_we) ? bus.mem_rdata : '0;

    case (r_state)
      ST_IDLE: w_state_nxt = ST_IDLE;
      ST_WAIT: begin
        if (r_lat_cnt != '0) begin
          w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A grant in the response cycle keeps the FSM in WAIT with no bubble
    if (w_grant) begin
      w_state_nxt   = ST_WAIT;
      w_owner_nxt   = w_winner;
      w_own_we_nxt  = w_req.we;
      w_lat_cnt_nxt = LAT_LOAD;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: one instance at MEM_LATENCY=2, one at 1.
module tb_unified_mem_arbiter;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  int unsigned cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter_if bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : 1;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] pipe    [LAT];
    logic [31:0] rd;
    exp_t        q [$];

    unified_mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     = 32'hC0DE_0000 + 32'(i);
        ref_mem[i] = 32'hC0DE_0000 + 32'(i);
      end
    end

    // Memory model: read data appears LAT cycles after mem_en, noise otherwise
    always @(posedge clk) begin
      rd = mem[bus[g].mem_addr[7:0]];
      if (bus[g].mem_en && bus[g].mem_we) mem[bus[g].mem_addr[7:0]] = bus[g].mem_wdata;
      pipe[0] <= (bus[g].mem_en && !bus[g].mem_we) ? rd : $urandom();
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign bus[g].mem_rdata = pipe[LAT-1];

    always @(negedge clk) begin : mon
      exp_t        e;
      logic [65:0] exp_v;
      logic [65:0] act_v;
      if (reset) begin
        q.delete();
      end else begin
        if (bus[g].d_gnt === 1'b1) begin
          e.is_d = 1'b1;
          e.due  = cyc + LAT;
          e.data = bus[g].d_we ? 32'h0 : ref_mem[bus[g].d_addr[9:2]];
          if (bus[g].d_we) ref_mem[bus[g].d_addr[9:2]] = bus[g].d_wdata;
          q.push_back(e);
        end
        if (bus[g].if_gnt === 1'b1) begin
          e.is_d = 1'b0;
          e.due  = cyc + LAT;
          e.data = ref_mem[bus[g].if_addr[9:2]];
          q.push_back(e);
        end
        exp_v = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e     = q.pop_front();
          exp_v = e.is_d ? {2'b01, 32'h0, e.data} : {2'b10, e.data, 32'h0};
        end
        act_v = {bus[g].if_rvalid, bus[g].d_rvalid, bus[g].if_rdata, bus[g].d_rdata};
        n_checks++;
        if (act_v !== exp_v)
          $display("FAIL resp[%0d] cyc %0d: got %h, expected %h", g, cyc, act_v, exp_v);
        else
          n_pass++;
      end
    end
  end

  function automatic logic [131:0] outs0();
    return {bus[0].if_gnt, bus[0].if_rvalid, bus[0].if_rdata, bus[0].d_gnt, bus[0].d_rvalid,
            bus[0].d_rdata, bus[0].mem_en, bus[0].mem_we, bus[0].mem_addr, bus[0].mem_wdata};
  endfunction

  function automatic logic [131:0] outs1();
    return {bus[1].if_gnt, bus[1].if_rvalid, bus[1].if_rdata, bus[1].d_gnt, bus[1].d_rvalid,
            bus[1].d_rdata, bus[1].mem_en, bus[1].mem_we, bus[1].mem_addr, bus[1].mem_wdata};
  endfunction

  task automatic drop_reqs();
    bus[0].if_req = 1'b0;
    bus[0].d_req  = 1'b0;
    bus[1].if_req = 1'b0;
    bus[1].d_req  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (outs0() !== '0) $display("FAIL reset_outs0: got %h, expected 0", outs0());
    else n_pass++;
    n_checks++;
    if (outs1() !== '0) $display("FAIL reset_outs1: got %h, expected 0", outs1());
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [33:0] act;
    @(posedge clk); #1;
    bus[0].if_req  = 1'b1;
    bus[0].if_addr = 32'h10;
    @(negedge clk);
    act = {bus[0].if_gnt, bus[0].d_gnt, bus[0].mem_en, bus[0].mem_we, bus[0].mem_addr};
    n_checks++;
    if (act !== {4'b1010, 30'h4}) $display("FAIL fetch_gnt: got %h, expected %h", act, {4'b1010, 30'h4});
    else n_pass++;
    @(posedge clk); #1;
    drop_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    logic [65:0] act;
    @(posedge clk); #1;
    bus[0].d_req   = 1'b1;
    bus[0].d_we    = 1'b1;
    bus[0].d_addr  = 32'h20;
    bus[0].d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    act = {bus[0].d_gnt, bus[0].if_gnt, bus[0].mem_en, bus[0].mem_we, bus[0].mem_addr, bus[0].mem_wdata};
    n_checks++;
    if (act !== {4'b1011, 30'h8, 32'hDEADBEEF})
      $display("FAIL write_gnt: got %h, expected %h", act, {4'b1011, 30'h8, 32'hDEADBEEF});
    else n_pass++;
    @(posedge clk); #1;
    drop_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_after_write();
    logic [33:0] act;
    @(posedge clk); #1;
    bus[0].d_req  = 1'b1;
    bus[0].d_we   = 1'b0;
    bus[0].d_addr = 32'h20;
    @(negedge clk);
    act = {bus[0].d_gnt, bus[0].if_gnt, bus[0].mem_en, bus[0].mem_we, bus[0].mem_addr};
    n_checks++;
    if (act !== {4'b1010, 30'h8}) $display("FAIL raw_gnt: got %h, expected %h", act, {4'b1010, 30'h8});
    else n_pass++;
    @(posedge clk); #1;
    drop_reqs();
    repeat (2) @(negedge clk);
    act = {bus[0].if_rvalid, bus[0].d_rvalid, bus[0].d_rdata};
    n_checks++;
    if (act !== {2'b01, 32'hDEADBEEF}) $display("FAIL raw_data: got %h, expected %h", act, {2'b01, 32'hDEADBEEF});
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    @(posedge clk); #1;
    bus[0].if_req  = 1'b1;
    bus[0].if_addr = 32'h80;
    bus[0].d_req   = 1'b1;
    bus[0].d_we    = 1'b0;
    bus[0].d_addr  = 32'h40;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_g = (i % 2 != 0) ? 2'b00 : ((i == 8 || i == 18) ? 2'b10 : 2'b01);
      n_checks++;
      if ({bus[0].if_gnt, bus[0].d_gnt} !== exp_g)
        $display("FAIL b2b_gnt[%0d]: got %b, expected %b", i, {bus[0].if_gnt, bus[0].d_gnt}, exp_g);
      else n_pass++;
    end
    @(posedge clk); #1;
    drop_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [33:0] act;
    @(posedge clk); #1;
    bus[0].if_req  = 1'b1;
    bus[0].if_addr = 32'h30;
    @(negedge clk);
    n_checks++;
    if ({bus[0].if_gnt, bus[0].d_gnt, bus[0].mem_en} !== 3'b101)
      $display("FAIL rmid_gnt: got %b, expected 101", {bus[0].if_gnt, bus[0].d_gnt, bus[0].mem_en});
    else n_pass++;
    @(posedge clk); #1;
    drop_reqs();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs0() !== '0) $display("FAIL rmid_outs: got %h, expected 0", outs0());
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus[0].if_rvalid, bus[0].d_rvalid} !== 2'b00)
      $display("FAIL rmid_dropped: got %b, expected 00", {bus[0].if_rvalid, bus[0].d_rvalid});
    else n_pass++;
    @(posedge clk); #1;
    bus[0].d_req  = 1'b1;
    bus[0].d_we   = 1'b0;
    bus[0].d_addr = 32'h20;
    @(negedge clk);
    act = {bus[0].if_gnt, bus[0].d_gnt, bus[0].mem_en, bus[0].mem_we, bus[0].mem_addr};
    n_checks++;
    if (act !== {4'b0110, 30'h8}) $display("FAIL rmid_regnt: got %h, expected %h", act, {4'b0110, 30'h8});
    else n_pass++;
    @(posedge clk); #1;
    drop_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency1();
    int          kind [4] = '{0, 1, 0, 2};
    logic [31:0] addr [4] = '{32'h0, 32'h44, 32'h8, 32'h44};
    logic [31:0] rdat [4] = '{32'hC0DE_0000, 32'h0, 32'hC0DE_0002, 32'h1234_5678};
    logic [1:0]  exp_g;
    logic [33:0] act;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (kind[i] == 0) begin
        bus[1].if_req  = 1'b1;
        bus[1].if_addr = addr[i];
      end else begin
        bus[1].d_req   = 1'b1;
        bus[1].d_we    = (kind[i] == 1);
        bus[1].d_addr  = addr[i];
        bus[1].d_wdata = 32'h1234_5678;
      end
      exp_g = (kind[i] == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_checks++;
      if ({bus[1].if_gnt, bus[1].d_gnt} !== exp_g)
        $display("FAIL lat1_gnt[%0d]: got %b, expected %b", i, {bus[1].if_gnt, bus[1].d_gnt}, exp_g);
      else n_pass++;
      @(posedge clk); #1;
      drop_reqs();
      @(negedge clk);
      act = {bus[1].if_rvalid, bus[1].d_rvalid, (kind[i] == 0) ? bus[1].if_rdata : bus[1].d_rdata};
      n_checks++;
      if (act !== {exp_g, rdat[i]}) $display("FAIL lat1_resp[%0d]: got %h, expected %h", i, act, {exp_g, rdat[i]});
      else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int g = 0; g < 1; g++) begin
      drop_reqs();
    end
    bus[0].if_addr = '0; bus[0].d_we = 1'b0; bus[0].d_addr = '0; bus[0].d_wdata = '0;
    bus[1].if_addr = '0; bus[1].d_we = 1'b0; bus[1].d_addr = '0; bus[1].d_wdata = '0;
    test_reset();
    test_fetch();
    test_write();
    test_read_after_write();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
